pe_mac_bank: RTL

- Parametrised fixed-point processing element: signed multiply, then accumulate into one of NUM_ACC selectable accumulator banks.
- Banks are flushed through a rounding/saturation formatter to a valid/ready output.
- Successor PE for the systolic/MAC array. Adds generic bank count, guard bits, selectable rounding, saturation flagging and backpressure.

---
 rtl/pe_mac_bank.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/pe_mac_bank.sv
// pe_mac_bank: signed fixed-point multiply-accumulate processing element.
// Products are accumulated into one of NUM_ACC guarded accumulator banks.
// Flushed banks are rounded, saturated and presented on a valid/ready output.
// Backpressure stalls the whole three-stage pipe as one unit.
module pe_mac_bank #(
    parameter int INT_BITS   = 7,
    parameter int FRAC_BITS  = 9,
    parameter int NUM_ACC    = 8,
    parameter int GUARD_BITS = 4,
    localparam int W  = INT_BITS + FRAC_BITS,
    localparam int AW = 2 * W + GUARD_BITS,
    localparam int SW = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    input  logic [SW-1:0]       acc_sel_i,
    input  logic                clear_i,
    input  logic                flush_i,
    input  logic                round_mode_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [W-1:0]        out_data_o,
    output logic [SW-1:0]       out_sel_o,
    output logic                out_sat_o
);

    localparam int PW = 2 * W;
    localparam int RW = AW - FRAC_BITS + 1;
    localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
    localparam logic [W-1:0]  OUT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  OUT_MIN = {1'b1, {(W-1){1'b0}}};

    logic                en;
    logic signed [PW-1:0] prodFull;

    logic                s1Valid_q;
    logic [PW-1:0]       s1Prod_q;
    logic [SW-1:0]       s1Sel_q;
    logic                s1Clear_q;
    logic                s1Flush_q;
    logic                s1Round_q;

    logic [AW-1:0]       bank_q [NUM_ACC];
    logic                sticky_q [NUM_ACC];

    logic [AW-1:0]       bankRd;
    logic                stickyRd;
    logic                selHit;
    logic [AW-1:0]       prodExt;
    logic [AW-1:0]       accBase;
    logic [AW:0]         sumWide;
    logic                sumOvf;
    logic [AW-1:0]       bank_d;
    logic                sticky_d;
    logic                s2Fire;

    logic                s2Valid_q;
    logic [AW-1:0]       s2Sum_q;
    logic                s2Sticky_q;
    logic [SW-1:0]       s2Sel_q;
    logic                s2Round_q;

    logic [RW-1:0]       shifted;
    logic [FRAC_BITS-1:0] remBits;
    logic [FRAC_BITS-1:0] remLow;
    logic                roundInc;
    logic [RW-1:0]       rounded;
    logic                satHi;
    logic                satLo;
    logic [W-1:0]        fmtData_d;
    logic                fmtSat_d;

    logic                outValid_q;
    logic [W-1:0]        outData_q;
    logic [SW-1:0]       outSel_q;
    logic                outSat_q;

    assign en         = !outValid_q || out_ready_i;
    assign in_ready_o = en;
    assign prodFull   = PW'(a_i) * PW'(b_i);

    assign out_valid_o = outValid_q;
    assign out_data_o  = outData_q;
    assign out_sel_o   = outSel_q;
    assign out_sat_o   = outSat_q;

    // Stage 1: capture the full-precision product and the beat's control fields.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1Valid_q <= 1'b0;
            s1Prod_q  <= '0;
            s1Sel_q   <= '0;
            s1Clear_q <= 1'b0;
            s1Flush_q <= 1'b0;
            s1Round_q <= 1'b0;
        end else if (en) begin
            s1Valid_q <= in_valid_i;
            s1Prod_q  <= prodFull;
            s1Sel_q   <= acc_sel_i;
            s1Clear_q <= clear_i;
            s1Flush_q <= flush_i;
            s1Round_q <= round_mode_i;
        end
    end

    // Stage 2 read-modify-write: select the bank, add the product, saturate on overflow.
    always_comb begin
        bankRd   = '0;
        stickyRd = 1'b0;
        selHit   = 1'b0;
        for (int i = 0; i < NUM_ACC; i++) begin
            if (s1Sel_q == SW'(i)) begin
                bankRd   = bank_q[i];
                stickyRd = sticky_q[i];
                selHit   = 1'b1;
            end
        end
        prodExt  = {{GUARD_BITS{s1Prod_q[PW-1]}}, s1Prod_q};
        accBase  = s1Clear_q ? '0 : bankRd;
        sumWide  = {accBase[AW-1], accBase} + {prodExt[AW-1], prodExt};
        sumOvf   = sumWide[AW] ^ sumWide[AW-1];
        bank_d   = sumOvf ? (sumWide[AW] ? ACC_MIN : ACC_MAX) : sumWide[AW-1:0];
        sticky_d = (s1Clear_q ? 1'b0 : stickyRd) | sumOvf;
        s2Fire   = s1Valid_q && selHit;
    end

    // Bank storage: write the new sum, or zero the bank once it has been flushed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                bank_q[i]   <= '0;
                sticky_q[i] <= 1'b0;
            end
        end else if (en && s2Fire) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                if (s1Sel_q == SW'(i)) begin
                    if (s1Flush_q) begin
                        bank_q[i]   <= '0;
                        sticky_q[i] <= 1'b0;
                    end else begin
                        bank_q[i]   <= bank_d;
                        sticky_q[i] <= sticky_d;
                    end
                end
            end
        end
    end

    // Stage 2 register: hand flushed sums and their sticky flag to the formatter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2Valid_q  <= 1'b0;
            s2Sum_q    <= '0;
            s2Sticky_q <= 1'b0;
            s2Sel_q    <= '0;
            s2Round_q  <= 1'b0;
        end else if (en) begin
            s2Valid_q  <= s2Fire && s1Flush_q;
            s2Sum_q    <= bank_d;
            s2Sticky_q <= sticky_d;
            s2Sel_q    <= s1Sel_q;
            s2Round_q  <= s1Round_q;
        end
    end

    // Formatter: drop FRAC_BITS, optionally round half to even, clamp to W bits.
    always_comb begin
        shifted   = {s2Sum_q[AW-1], s2Sum_q[AW-1:FRAC_BITS]};
        remBits   = s2Sum_q[FRAC_BITS-1:0];
        remLow    = remBits << 1;
        roundInc  = s2Round_q && remBits[FRAC_BITS-1] && ((|remLow) || shifted[0]);
        rounded   = shifted + RW'(roundInc);
        satHi     = !rounded[RW-1] && (|rounded[RW-2:W-1]);
        satLo     = rounded[RW-1] && !(&rounded[RW-2:W-1]);
        fmtData_d = satHi ? OUT_MAX : (satLo ? OUT_MIN : rounded[W-1:0]);
        fmtSat_d  = satHi || satLo;
    end

    // Stage 3 output register: load a new result or retire the one just consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outSel_q   <= '0;
            outSat_q   <= 1'b0;
        end else if (en) begin
            if (s2Valid_q) begin
                outValid_q <= 1'b1;
                outData_q  <= fmtData_d;
                outSel_q   <= s2Sel_q;
                outSat_q   <= fmtSat_d || s2Sticky_q;
            end else begin
                outValid_q <= 1'b0;
            end
        end
    end

endmodule
